// File: rtl/mem_req_sequencer_if.sv
// rtl/mem_req_sequencer_if.sv - request, response and controller-side signal bundle for mem_req_sequencer
interface mem_req_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    // upstream request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // controller strobes and data
    logic              enable_write;
    logic              enable_read;
    logic [ADDR_W-1:0] addr_mm;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    // read response channel
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;

    logic              busy;

    // master is the environment: the upstream client plus the memory controller
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, data_out,
        input  req_ready, enable_write, enable_read, addr_mm, data_in,
               rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, data_out,
        output req_ready, enable_write, enable_read, addr_mm, data_in,
               rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/mem_req_sequencer.sv
// rtl/mem_req_sequencer.sv - request FIFO and strobe sequencer in front of the memory controller (optional stats via MEM_REQ_SEQ_STATS_EN)
module mem_req_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_req_sequencer_if.slave     bus
`ifdef MEM_REQ_SEQ_STATS_EN
    ,
    output logic [DATA_W-1:0]      wr_count,
    output logic [DATA_W-1:0]      rd_count
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [PTR_W:0] DEPTH_CNT = FIFO_DEPTH[PTR_W:0];
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              full, empty, push, pop;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              en_wr_q, en_wr_d;
    logic              en_rd_q, en_rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // a full FIFO refuses the push even when the sequencer pops in the same cycle
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign push  = bus.req_valid && !full;

    assign {head_we, head_addr, head_wdata} = fifo_mem[rd_ptr_q];

    // FIFO storage; contents need no reset because count_q gates every read
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {bus.req_we, bus.req_addr, bus.req_wdata};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // sequencer state and registered controller/response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            en_wr_q     <= 1'b0;
            en_rd_q     <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_wr_q     <= en_wr_d;
            en_rd_q     <= en_rd_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // next-state logic; returning to IDLE after every transaction forces a low cycle on the strobes
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en_wr_d     = en_wr_q;
        en_rd_d     = en_rd_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    addr_d = head_addr;
                    if (head_we) begin
                        din_d   = head_wdata;
                        en_wr_d = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        en_rd_d = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                en_wr_d = 1'b0;
                state_d = S_IDLE;
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = bus.data_out;
                    en_rd_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready    = !full;
    assign bus.busy         = !empty || (state_q != S_IDLE);
    assign bus.enable_write = en_wr_q;
    assign bus.enable_read  = en_rd_q;
    assign bus.addr_mm      = addr_q;
    assign bus.data_in      = din_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;

`ifdef MEM_REQ_SEQ_STATS_EN
    logic [DATA_W-1:0] wr_cnt_q, rd_cnt_q;

    // saturating transaction counters: writes counted in WRITE, reads at the response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (state_q == S_WRITE && wr_cnt_q != {DATA_W{1'b1}})
                wr_cnt_q <= wr_cnt_q + 1'b1;
            if (state_q == S_RESP && bus.rsp_ready && rd_cnt_q != {DATA_W{1'b1}})
                rd_cnt_q <= rd_cnt_q + 1'b1;
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`endif
endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb/tb_mem_req_sequencer.sv - self-checking bench for mem_req_sequencer
module tb_mem_req_sequencer;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_req_sequencer_if #(.ADDR_W(5), .DATA_W(16)) bus ();

`ifdef MEM_REQ_SEQ_STATS_EN
    logic [15:0] wr_count, rd_count;
`endif

    mem_req_sequencer #(.ADDR_W(5), .DATA_W(16), .FIFO_DEPTH(4), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef MEM_REQ_SEQ_STATS_EN
        ,
        .wr_count (wr_count),
        .rd_count (rd_count)
`endif
    );

    // controller model: stores on enable_write, presents stored word at addr_mm
    logic [15:0] ctrl_mem [32];
    assign bus.data_out = ctrl_mem[bus.addr_mm];
    always @(posedge clk) if (bus.enable_write) ctrl_mem[bus.addr_mm] <= bus.data_in;

    int n_vec = 0;
    int n_fail = 0;
    logic [15:0] rq[$];
    logic [20:0] wq[$];

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [4:0] a, input logic [15:0] d,
                        input logic [15:0] e, output int waits);
        logic acc;
        waits = 0;
        acc = 1'b0;
        if (we) wq.push_back({a, d});
        else    rq.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = bus.req_ready;
            tick();
            if (!acc) waits++;
        end
        bus.req_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (!bus.busy && rq.size() == 0 && wq.size() == 0) break;
            tick();
        end
        check("drain_busy", bus.busy, 0);
        check("drain_rq", rq.size(), 0);
    endtask

    // monitor: strobe widths/exclusivity, write contents and read responses against the scoreboard
    int er_run = 0;
    int ew_run = 0;
    logic [20:0] mon_w;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            er_run = 0;
            ew_run = 0;
        end else begin
            if (bus.enable_read && bus.enable_write) check("strobe_overlap", 1, 0);
            if (bus.enable_write) begin
                ew_run++;
                if (ew_run == 1) begin
                    if (wq.size() == 0) check("unexpected_write", 1, 0);
                    else begin
                        mon_w = wq.pop_front();
                        check("wr_addr", bus.addr_mm, mon_w[20:16]);
                        check("wr_data", bus.data_in, mon_w[15:0]);
                    end
                end
            end else begin
                if (ew_run != 0) check("ew_width", ew_run, 1);
                ew_run = 0;
            end
            if (bus.enable_read) er_run++;
            else begin
                if (er_run != 0) check("er_width", er_run, RD_LAT);
                er_run = 0;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rq.size() == 0) check("unexpected_rsp", 1, 0);
                else check("rsp_data", bus.rsp_data, rq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int w;
    initial begin
        vt[0] = '{1'b1, 5'h01, 16'h1111, 16'h0000};
        vt[1] = '{1'b1, 5'h02, 16'h2222, 16'h0000};
        vt[2] = '{1'b0, 5'h01, 16'h0000, 16'h1111};
        vt[3] = '{1'b1, 5'h01, 16'hAAAA, 16'h0000};
        vt[4] = '{1'b0, 5'h01, 16'h0000, 16'hAAAA};
        vt[5] = '{1'b0, 5'h02, 16'h0000, 16'h2222};
        vt[6] = '{1'b1, 5'h1F, 16'hFFFF, 16'h0000};
        vt[7] = '{1'b0, 5'h1F, 16'h0000, 16'hFFFF};
        vt[8] = '{1'b1, 5'h00, 16'h5A5A, 16'h0000};
        vt[9] = '{1'b0, 5'h00, 16'h0000, 16'h5A5A};

        for (int i = 0; i < 32; i++) ctrl_mem[i] = 16'h0000;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) tick();
        check("rst_outputs",
              {bus.req_ready, bus.busy, bus.enable_write, bus.enable_read, bus.rsp_valid},
              5'b10000);
        check("rst_regs", {bus.addr_mm, bus.data_in, bus.rsp_data}, 37'h0);
        rst = 1'b0;

        // idle after reset release
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle", {bus.req_ready, bus.busy, bus.enable_write, bus.enable_read, bus.rsp_valid},
                  5'b10000);
        end

        // single write timing
        wq.push_back({5'h0A, 16'hBEEF});
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 5'h0A; bus.req_wdata = 16'hBEEF;
        tick();
        bus.req_valid = 1'b0;
        check("wr_edgeA", bus.enable_write, 0);
        tick();
        check("wr_edgeA1", {bus.enable_write, bus.addr_mm, bus.data_in}, {1'b1, 5'h0A, 16'hBEEF});
        tick();
        check("wr_edgeA2", bus.enable_write, 0);
        drain();

        // single read timing
        bus.rsp_ready = 1'b1;
        rq.push_back(16'hBEEF);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 5'h0A;
        tick();
        bus.req_valid = 1'b0;
        check("rd_edgeA", bus.enable_read, 0);
        for (int i = 1; i <= RD_LAT; i++) begin
            tick();
            check("rd_hold", {bus.enable_read, bus.rsp_valid, bus.addr_mm}, {1'b1, 1'b0, 5'h0A});
        end
        tick();
        check("rd_resp", {bus.enable_read, bus.rsp_valid, bus.rsp_data}, {1'b0, 1'b1, 16'hBEEF});
        drain();

        // table-driven stream
        for (int i = 0; i < 10; i++) send(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, w);
        drain();

        // five reads with the consumer stalled
        bus.rsp_ready = 1'b0;
        send(1'b0, 5'h01, 16'h0, 16'hAAAA, w);
        send(1'b0, 5'h02, 16'h0, 16'h2222, w);
        send(1'b0, 5'h1F, 16'h0, 16'hFFFF, w);
        send(1'b0, 5'h00, 16'h0, 16'h5A5A, w);
        send(1'b0, 5'h0A, 16'h0, 16'hBEEF, w);
        check("full_ready", {bus.req_ready, bus.busy}, 2'b01);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_hold", {bus.req_ready, bus.rsp_valid, bus.rsp_data}, {1'b0, 1'b1, 16'hAAAA});
        end
        bus.rsp_ready = 1'b1;
        send(1'b0, 5'h01, 16'h0, 16'hAAAA, w);
        check("nobypass_wait", w, 2);
        drain();

        // reset in the middle of a read with more reads queued
        send(1'b0, 5'h02, 16'h0, 16'h2222, w);
        send(1'b0, 5'h01, 16'h0, 16'hAAAA, w);
        send(1'b0, 5'h1F, 16'h0, 16'hFFFF, w);
        check("pre_rst_read", bus.enable_read, 1);
        rst = 1'b1;
        #1;
        check("rst_abort", {bus.enable_read, bus.busy, bus.req_ready, bus.rsp_valid}, 4'b0010);
        rq.delete();
        wq.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_idle", {bus.enable_read, bus.rsp_valid, bus.busy}, 3'b000);
        end

        // three writes then two reads
        send(1'b1, 5'h03, 16'h0303, 16'h0, w);
        send(1'b1, 5'h04, 16'h0404, 16'h0, w);
        send(1'b1, 5'h05, 16'h0505, 16'h0, w);
        send(1'b0, 5'h03, 16'h0, 16'h0303, w);
        send(1'b0, 5'h05, 16'h0, 16'h0505, w);
        drain();
`ifdef MEM_REQ_SEQ_STATS_EN
        check("wr_count", wr_count, 3);
        check("rd_count", rd_count, 2);
`endif
        check("wq_empty", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
